sccb_write_master: RTL and testbench
====================================

Name: sccb_write_master

Overview:
- SCCB 3-phase write transmitter for the OV7670 control bus.
- Consumes {REG_ADDR, REG_VALUE} words from the register-init sequencer and serialises each one as an SCCB write to the camera's device ID.
- Pulses continue after every completed write so the sequencer advances.
- Stops once the sequencer reports done; the top-level SIOD tri-state is built from siod_out/siod_oe.

Parameters:
- QTR_CYCLES, 125, clk cycles per quarter SIOC period (50 MHz / (4*125) = 100 kHz SIOC); minimum 2.
- DEVICE_ID, 8'h42, SCCB write ID byte (7-bit addr 0x21, R/W=0).
- GAP_CYCLES, 50000, bus-idle clk cycles after each stop before continue pulses (covers the COM7 reset settle); minimum 1.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-high reset
- data  in  16  {REG_ADDR[15:8], REG_VALUE[7:0]} from sequencer
- done  in  1  sequencer finished; no further writes
- continue  out  1  one-cycle pulse: current word written, advance
- busy  out  1  high from transaction start through end of GAP
- sioc  out  1  SCCB clock
- siod_out  out  1  SCCB data value
- siod_oe  out  1  1 = drive siod_out, 0 = release SIOD (high-Z)

Behaviour:
- Reset (async, any state): state=HOLD, hold count=0, sioc=1, siod_out=1, siod_oe=1, continue=0, busy=0. Asserting reset mid-transaction truncates the frame immediately; no stop condition is generated.
- The quarter counter qcnt counts 0..QTR_CYCLES-1. Each wrap is a quarter tick. All bus outputs are registered and change only on quarter ticks, except in HOLD, IDLE and GAP.
- HOLD: waits 2 clk cycles after reset release or after a continue pulse, which lets the sequencer's data/done settle. Then goes to IDLE.
- IDLE: sioc=1, siod_out=1, siod_oe=1.
  - If done=1, remain in IDLE indefinitely.
  - Else latch the 27-bit shift register {DEVICE_ID, 1'b0, data[15:8], 1'b0, data[7:0], 1'b0}, MSB first. Set busy=1, clear qcnt, go to START.
- START, 2 quarters:
  - q0: siod_out=0 with sioc=1.
  - q1: sioc=0.
  - Then go to BIT with bit index 26.
- BIT, 4 quarters per bit:
  - q0: sioc=0, present the next bit.
  - q1: sioc=0.
  - q2: sioc=1.
  - q3: sioc=1.
  - Bit indices 18, 9 and 0 are don't-care/ACK slots: siod_oe=0 for the whole bit. All other bits: siod_oe=1, siod_out=bit.
  - The ACK value is never sampled; no NACK handling.
  - After bit 0 q3, go to STOP.
- STOP, 3 quarters:
  - q0: sioc=0, siod_oe=1, siod_out=0.
  - q1: sioc=1.
  - q2: siod_out=1 with sioc=1.
  - Then go to GAP.
- GAP: the bus is idle-high for GAP_CYCLES clk cycles. On the final cycle, pulse continue=1 for exactly 1 cycle and set busy=0, then go to HOLD.
- Transaction length, reset-free: (2 + 27*4 + 3) * QTR_CYCLES = 113*QTR_CYCLES cycles from leaving IDLE to entering GAP.
- data and done changes during busy are ignored; the word is latched at IDLE exit.
- continue never asserts while done=1 at IDLE, and never asserts twice for one word.
- data=16'hffff is never transmitted if done=1, since the sequencer's done flag is data==ffff.

Test Plan (QTR_CYCLES=4, GAP_CYCLES=8 in the bench):
- Single write: release reset, data=16'h1280, done=0 → start (SIOD falls, SIOC high); 27 SIOC rising edges; SIOD at the rises = 0100_0010 Z 0001_0010 Z 1000_0000 Z (Z means siod_oe=0); stop; continue pulses once, 452+8 cycles after IDLE exit.
- Chain with the real sequencer model (step advances on continue) → 12 writes observed in order: 1280, 1280, 1101, 6b7a, 1201, 0c00, 3e00, 703a, 7135, 7211, 73f0, a202. Then done=1: no further start condition, continue stays 0, busy=0, sioc=siod_out=1.
- Data change mid-frame: latch 16'h6b7a, then set data=16'h0000 at bit 20 → the bus still carries 6b7a.
- Async reset at bit 10 of a frame → on the same cycle sioc=1, siod_out=1, siod_oe=1, busy=0, continue=0. After release, the 2-cycle HOLD completes, then a new full frame of the current data is sent.
- done=1 held from reset release → no start condition ever, continue never asserts, outputs idle-high.
- Timing check: every SIOD transition inside BIT occurs while sioc=0. Start/stop SIOD edges occur only while sioc=1. SIOC high and low phases are each 2*QTR_CYCLES = 8 cycles.

Source files
------------

// File: rtl/sccb_write_master_if.sv
// SCCB write-master bus bundle: sequencer handshake plus the SIOC/SIOD pin drivers.
// The master modport is the transmitter side; the slave modport is the sequencer/pad side.
interface sccb_write_master_if;
  logic [15:0] data;
  logic        done;
  logic        continue_pulse;
  logic        busy;
  logic        sioc;
  logic        siod_out;
  logic        siod_oe;

  modport master (
    input  data, done,
    output continue_pulse, busy, sioc, siod_out, siod_oe
  );

  modport slave (
    output data, done,
    input  continue_pulse, busy, sioc, siod_out, siod_oe
  );
endinterface

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write transmitter (ID, register address, value) for the OV7670 control bus.
// Outputs are registered decodes of the next FSM position, so they only move on quarter ticks.
module sccb_write_master #(
  parameter int         QTR_CYCLES = 125,
  parameter logic [7:0] DEVICE_ID  = 8'h42,
  parameter int         GAP_CYCLES = 50000
) (
  input logic                 clk,
  input logic                 reset,
  sccb_write_master_if.master bus
);
  localparam int QW = $clog2(QTR_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_HOLD, S_IDLE, S_START, S_BIT, S_STOP, S_GAP} state_t;

  state_t          state_reg, state_next;
  logic [QW-1:0]   qcnt_reg, qcnt_next;
  logic [1:0]      phase_reg, phase_next;
  logic [4:0]      bit_idx_reg, bit_idx_next;
  logic [26:0]     shift_reg, shift_next;
  logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
  logic            hold_cnt_reg, hold_cnt_next;
  logic            sioc_reg, sioc_next;
  logic            siod_out_reg, siod_out_next;
  logic            siod_oe_reg, siod_oe_next;
  logic            busy_reg, busy_next;
  logic            cont_reg, cont_next;
  logic            qtick;
  logic            ack_slot;

  assign qtick    = (qcnt_reg == QTR_LAST);
  // Bits 18, 9 and 0 are the slave's don't-care/ACK slots; SIOD is released there.
  assign ack_slot = (bit_idx_next == 5'd18) || (bit_idx_next == 5'd9) || (bit_idx_next == 5'd0);

  assign bus.sioc           = sioc_reg;
  assign bus.siod_out       = siod_out_reg;
  assign bus.siod_oe        = siod_oe_reg;
  assign bus.busy           = busy_reg;
  assign bus.continue_pulse = cont_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_HOLD;
      qcnt_reg     <= '0;
      phase_reg    <= 2'd0;
      bit_idx_reg  <= 5'd0;
      shift_reg    <= '0;
      gap_cnt_reg  <= '0;
      hold_cnt_reg <= 1'b0;
      sioc_reg     <= 1'b1;
      siod_out_reg <= 1'b1;
      siod_oe_reg  <= 1'b1;
      busy_reg     <= 1'b0;
      cont_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      qcnt_reg     <= qcnt_next;
      phase_reg    <= phase_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      gap_cnt_reg  <= gap_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      sioc_reg     <= sioc_next;
      siod_out_reg <= siod_out_next;
      siod_oe_reg  <= siod_oe_next;
      busy_reg     <= busy_next;
      cont_reg     <= cont_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    qcnt_next     = qcnt_reg;
    phase_next    = phase_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    gap_cnt_next  = gap_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      S_HOLD: begin
        hold_cnt_next = ~hold_cnt_reg;
        if (hold_cnt_reg) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (!bus.done) begin
          shift_next = {DEVICE_ID, 1'b0, bus.data[15:8], 1'b0, bus.data[7:0], 1'b0};
          qcnt_next  = '0;
          phase_next = 2'd0;
          state_next = S_START;
        end
      end
      S_START, S_BIT, S_STOP: begin
        qcnt_next = qtick ? '0 : qcnt_reg + 1'b1;
        if (qtick) begin
          phase_next = phase_reg + 2'd1;
          if (state_reg == S_START && phase_reg == 2'd1) begin
            state_next   = S_BIT;
            phase_next   = 2'd0;
            bit_idx_next = 5'd26;
          end else if (state_reg == S_BIT && phase_reg == 2'd3) begin
            if (bit_idx_reg == 5'd0) begin
              state_next = S_STOP;
            end else begin
              bit_idx_next = bit_idx_reg - 5'd1;
              shift_next   = {shift_reg[25:0], 1'b0};
            end
          end else if (state_reg == S_STOP && phase_reg == 2'd2) begin
            state_next   = S_GAP;
            phase_next   = 2'd0;
            gap_cnt_next = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next    = S_HOLD;
          hold_cnt_next = 1'b0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = S_HOLD;
    endcase
  end

  always_comb begin
    sioc_next     = 1'b1;
    siod_out_next = 1'b1;
    siod_oe_next  = 1'b1;
    busy_next     = 1'b1;
    cont_next     = 1'b0;
    case (state_next)
      S_HOLD, S_IDLE: busy_next = 1'b0;
      S_START: begin
        siod_out_next = 1'b0;
        sioc_next     = (phase_next == 2'd0);
      end
      S_BIT: begin
        sioc_next     = phase_next[1];
        siod_out_next = shift_next[26];
        siod_oe_next  = !ack_slot;
      end
      S_STOP: begin
        sioc_next     = (phase_next != 2'd0);
        siod_out_next = (phase_next == 2'd2);
      end
      default: ;
    endcase
    if (state_reg == S_GAP && state_next == S_HOLD) cont_next = 1'b1;
  end
endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: a negedge bus monitor decodes SCCB frames and
// checks them against a scoreboard of expected words pushed by the stimulus sequence.
module tb_sccb_write_master;
  localparam int         Q         = 4;
  localparam int         G         = 8;
  localparam logic [7:0] DEV       = 8'h42;
  localparam int         FRAME_CYC = 113 * Q + G;
  localparam logic [26:0] OE_MASK  = 27'h7FBFDFE;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sccb_write_master_if bus ();

  sccb_write_master #(.QTR_CYCLES(Q), .DEVICE_ID(DEV), .GAP_CYCLES(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] seq_tbl [12] = '{16'h1280, 16'h1280, 16'h1101, 16'h6b7a, 16'h1201, 16'h0c00,
                                16'h3e00, 16'h703a, 16'h7135, 16'h7211, 16'h73f0, 16'ha202};

  int frames_seen = 0, starts_seen = 0, cont_count = 0;
  int nbits = 0, run_len = 0, cyc = 0, busy_rise = 0;
  logic in_frame = 1'b0;
  logic [26:0] rx_bits = '0, rx_oe = '0;
  logic p_sc = 1'b1, p_so = 1'b1, p_oe = 1'b1, p_busy = 1'b0, p_cont = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cont(input string tag, input int bound);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge clk);
      seen = bus.continue_pulse;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_nbits(input string tag, input int n, input int bound);
    logic reached;
    reached = 1'b0;
    for (int c = 0; c < bound && !reached; c++) begin
      @(posedge clk);
      reached = (nbits >= n);
    end
    chk(tag, 32'(reached), 32'd1);
  endtask

  task automatic restart(input logic [15:0] word);
    @(negedge clk);
    reset = 1'b1;
    bus.data = word;
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Bus monitor: frame decode, scoreboard pop, SIOC/SIOD timing and continue checks.
  initial begin
    logic sc, so, oe, start_ev, stop_ev, siod_chg;
    logic [15:0] exp_w;
    logic [26:0] exp_frame;
    forever begin
      @(negedge clk);
      cyc++;
      sc = bus.sioc;
      so = bus.siod_out;
      oe = bus.siod_oe;
      if (reset) begin
        in_frame = 1'b0;
        nbits = 0;
      end else begin
        start_ev = !in_frame && p_sc && sc && p_oe && p_so && oe && !so;
        stop_ev  = in_frame && p_sc && sc && p_oe && !p_so && oe && so;
        siod_chg = (oe != p_oe) || (so != p_so);
        if (start_ev) begin
          in_frame = 1'b1;
          nbits = 0;
          starts_seen++;
        end else if (in_frame) begin
          if (siod_chg && !stop_ev) chk("siod_change_sioc_low", 32'(sc), 32'd0);
          if (sc != p_sc) begin
            if (sc && nbits >= 1 && nbits < 27) chk("sioc_low_len", run_len, 2 * Q);
            if (!sc && nbits >= 1) chk("sioc_high_len", run_len, 2 * Q);
            if (sc && nbits < 27) begin
              rx_bits = {rx_bits[25:0], so};
              rx_oe   = {rx_oe[25:0], oe};
              nbits++;
            end
          end
          if (stop_ev) begin
            in_frame = 1'b0;
            frames_seen++;
            chk("frame_bit_count", nbits, 27);
            chk("frame_expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              exp_w = exp_q.pop_front();
              exp_frame = {DEV, 1'b0, exp_w[15:8], 1'b0, exp_w[7:0], 1'b0};
              chk("frame_oe_mask", 32'(rx_oe), 32'(OE_MASK));
              chk("frame_data", 32'(rx_bits & rx_oe), 32'(exp_frame & OE_MASK));
              $display("frame %0d word=%h rx=%h", frames_seen, exp_w, rx_bits & rx_oe);
            end
          end
        end
        if (bus.busy && !p_busy) busy_rise = cyc;
        if (bus.continue_pulse) begin
          cont_count++;
          chk("cont_latency", cyc - busy_rise, FRAME_CYC);
          chk("cont_busy_low", 32'(bus.busy), 32'd0);
          chk("cont_width", 32'(p_cont), 32'd0);
        end
      end
      run_len = (sc != p_sc) ? 1 : run_len + 1;
      p_sc = sc;
      p_so = so;
      p_oe = oe;
      p_busy = bus.busy;
      p_cont = bus.continue_pulse;
    end
  end

  initial begin
    int f0, c0, s0;
    reset = 1'b1;
    bus.data = 16'hffff;
    bus.done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.sioc, bus.siod_out, bus.siod_oe, bus.busy, bus.continue_pulse}, 5'b11100);

    // done held from reset release: bus must stay idle forever
    reset = 1'b0;
    repeat (600) @(negedge clk);
    chk("done_idle_starts", starts_seen, 0);
    chk("done_idle_cont", cont_count, 0);
    chk("done_idle_outputs", {bus.sioc, bus.siod_out, bus.siod_oe, bus.busy, bus.continue_pulse}, 5'b11100);

    // single write of 1280
    restart(16'h1280);
    exp_q.push_back(16'h1280);
    reset = 1'b0;
    wait_cont("single_cont", 2000);
    bus.done = 1'b1;
    bus.data = 16'hffff;
    repeat (100) @(negedge clk);
    chk("single_frames", frames_seen, 1);
    chk("single_cont_count", cont_count, 1);

    // sequencer chain: data advances on every continue, then done
    restart(seq_tbl[0]);
    foreach (seq_tbl[i]) exp_q.push_back(seq_tbl[i]);
    f0 = frames_seen; c0 = cont_count; s0 = starts_seen;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_cont("chain_cont", 3000);
      if (i < 11) bus.data = seq_tbl[i + 1];
      else begin
        bus.data = 16'hffff;
        bus.done = 1'b1;
      end
    end
    repeat (600) @(negedge clk);
    chk("chain_frames", frames_seen - f0, 12);
    chk("chain_cont_count", cont_count - c0, 12);
    chk("chain_starts", starts_seen - s0, 12);
    chk("chain_queue_empty", exp_q.size(), 0);
    chk("chain_idle_outputs", {bus.sioc, bus.siod_out, bus.siod_oe, bus.busy, bus.continue_pulse}, 5'b11100);

    // data change mid-frame must not disturb the latched word
    restart(16'h6b7a);
    exp_q.push_back(16'h6b7a);
    f0 = frames_seen;
    reset = 1'b0;
    wait_nbits("midframe_reach_bit20", 7, 2000);
    #1 bus.data = 16'h0000;
    wait_cont("midframe_cont", 2000);
    bus.done = 1'b1;
    repeat (100) @(negedge clk);
    chk("midframe_frames", frames_seen - f0, 1);
    chk("midframe_queue_empty", exp_q.size(), 0);

    // async reset at bit 10 truncates the frame; a full resend follows
    restart(16'h7135);
    f0 = frames_seen;
    reset = 1'b0;
    wait_nbits("reset_reach_bit10", 17, 2000);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {bus.sioc, bus.siod_out, bus.siod_oe, bus.busy, bus.continue_pulse}, 5'b11100);
    @(negedge clk);
    exp_q.push_back(16'h7135);
    @(negedge clk);
    reset = 1'b0;
    wait_cont("reset_resend_cont", 2000);
    bus.done = 1'b1;
    repeat (100) @(negedge clk);
    chk("reset_resend_frames", frames_seen - f0, 1);
    chk("reset_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
